// File: rtl/dsp_path_ctrl.sv
// Packet-boundary-safe bypass/DSP scheduler with drained mode switching and drain timeout.
// Optional packet statistics are built when DSP_PATH_CTRL_STATS_EN is defined.
module dsp_path_ctrl #(
    parameter int unsigned OUTST_W       = 4,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_fir_enable,
    input  logic        cfg_dft_enable,
    input  logic        err_clr,
    output logic        snk_ready,
    input  logic [31:0] snk_data,
    input  logic        snk_valid,
    input  logic        snk_sop,
    input  logic        snk_eop,
    output logic [31:0] src_data,
    output logic        src_valid,
    output logic        src_sop,
    output logic        src_eop,
    input  logic        src_ready,
    input  logic        dsp_snk_ready,
    output logic [31:0] dsp_snk_data,
    output logic        dsp_snk_valid,
    output logic        dsp_snk_sop,
    output logic        dsp_snk_eop,
    input  logic [31:0] dsp_src_data,
    input  logic        dsp_src_valid,
    input  logic        dsp_src_sop,
    input  logic        dsp_src_eop,
    output logic        dsp_src_ready,
    output logic        dsp_flush,
    output logic [1:0]  stat_mode,
    output logic        stat_drain_err,
    output logic [15:0] stat_byp_pkts,
    output logic [15:0] stat_dsp_pkts
);

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_DSP    = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic               in_pkt;
    logic               in_pkt_nxt;
    logic               out_pkt;
    logic               out_pkt_nxt;
    logic [OUTST_W-1:0] outst;
    logic [OUTST_W-1:0] outst_nxt;
    logic [TMR_W-1:0]   drain_tmr;
    logic               drain_timeout;
    logic               req_dsp;
    logic               full_block;
    logic               in_xfer;
    logic               out_xfer;
    logic               in_eop;
    logic               out_eop;
    logic               outst_inc;

    assign req_dsp    = cfg_fir_enable | cfg_dft_enable;
    // Input is held off only at a packet boundary so a started packet always completes.
    assign full_block = !in_pkt && (outst == '1);

    always_comb begin
        src_data      = dsp_src_data;
        src_valid     = dsp_src_valid;
        src_sop       = dsp_src_sop;
        src_eop       = dsp_src_eop;
        dsp_src_ready = src_ready;
        snk_ready     = 1'b0;
        dsp_snk_data  = snk_data;
        dsp_snk_valid = 1'b0;
        dsp_snk_sop   = snk_sop;
        dsp_snk_eop   = snk_eop;
        case (state)
            ST_BYPASS: begin
                src_data      = snk_data;
                src_valid     = snk_valid;
                src_sop       = snk_sop;
                src_eop       = snk_eop;
                snk_ready     = src_ready;
                dsp_src_ready = 1'b0;
            end
            ST_DSP: begin
                snk_ready     = dsp_snk_ready & !full_block;
                dsp_snk_valid = snk_valid & !full_block;
            end
            default: ;
        endcase
    end

    assign in_xfer     = snk_valid & snk_ready;
    assign out_xfer    = dsp_src_valid & dsp_src_ready;
    assign in_eop      = in_xfer & snk_eop;
    assign out_eop     = out_xfer & dsp_src_eop;
    assign outst_inc   = in_eop & (state == ST_DSP);
    assign in_pkt_nxt  = in_xfer ? !snk_eop : in_pkt;
    assign out_pkt_nxt = out_xfer ? !dsp_src_eop : out_pkt;

    always_comb begin
        outst_nxt = outst;
        case ({outst_inc, out_eop})
            2'b10:   outst_nxt = outst + OUTST_W'(1);
            2'b01:   outst_nxt = outst - OUTST_W'(1);
            default: outst_nxt = outst;
        endcase
    end

    // In DRAIN a re-request wins, then a clean drain, and only then the forced timeout exit.
    always_comb begin
        state_nxt     = state;
        drain_timeout = 1'b0;
        case (state)
            ST_BYPASS: begin
                if (req_dsp && !in_pkt_nxt)
                    state_nxt = ST_DSP;
            end
            ST_DSP: begin
                if (!req_dsp && !in_pkt_nxt)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (req_dsp) begin
                    state_nxt = ST_DSP;
                end else if ((outst_nxt == '0) && !out_pkt_nxt) begin
                    state_nxt = ST_BYPASS;
                end else if (drain_tmr == TMR_LAST) begin
                    state_nxt     = ST_BYPASS;
                    drain_timeout = 1'b1;
                end
            end
            default: state_nxt = ST_BYPASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_BYPASS;
            in_pkt         <= 1'b0;
            out_pkt        <= 1'b0;
            outst          <= '0;
            drain_tmr      <= '0;
            stat_drain_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            in_pkt  <= in_pkt_nxt;
            out_pkt <= drain_timeout ? 1'b0 : out_pkt_nxt;
            outst   <= drain_timeout ? '0 : outst_nxt;
            if (state == ST_DRAIN)
                drain_tmr <= drain_tmr + TMR_W'(1);
            else
                drain_tmr <= '0;
            if (drain_timeout)
                stat_drain_err <= 1'b1;
            else if (err_clr)
                stat_drain_err <= 1'b0;
        end
    end

    assign dsp_flush = drain_timeout;
    assign stat_mode = state;

`ifdef DSP_PATH_CTRL_STATS_EN
    logic [15:0] byp_cnt;
    logic [15:0] dsp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_cnt <= '0;
            dsp_cnt <= '0;
        end else begin
            if ((state == ST_BYPASS) && in_eop)
                byp_cnt <= byp_cnt + 16'd1;
            if (out_eop)
                dsp_cnt <= dsp_cnt + 16'd1;
        end
    end

    assign stat_byp_pkts = byp_cnt;
    assign stat_dsp_pkts = dsp_cnt;
`else
    assign stat_byp_pkts = '0;
    assign stat_dsp_pkts = '0;
`endif

endmodule

// File: tb/tb_dsp_path_ctrl.sv
// Directed self-checking bench for dsp_path_ctrl; the bench itself plays the DSP block.
module tb_dsp_path_ctrl;

`ifdef DSP_PATH_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cfg_fir_enable;
    logic        cfg_dft_enable;
    logic        err_clr;
    logic        snk_ready;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_sop;
    logic        snk_eop;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic        src_ready;
    logic        dsp_snk_ready;
    logic [31:0] dsp_snk_data;
    logic        dsp_snk_valid;
    logic        dsp_snk_sop;
    logic        dsp_snk_eop;
    logic [31:0] dsp_src_data;
    logic        dsp_src_valid;
    logic        dsp_src_sop;
    logic        dsp_src_eop;
    logic        dsp_src_ready;
    logic        dsp_flush;
    logic [1:0]  stat_mode;
    logic        stat_drain_err;
    logic [15:0] stat_byp_pkts;
    logic [15:0] stat_dsp_pkts;

    int n_assert = 0;
    int n_fail   = 0;

    dsp_path_ctrl #(
        .OUTST_W       (2),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_fir_enable (cfg_fir_enable),
        .cfg_dft_enable (cfg_dft_enable),
        .err_clr        (err_clr),
        .snk_ready      (snk_ready),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_sop        (snk_sop),
        .snk_eop        (snk_eop),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .src_ready      (src_ready),
        .dsp_snk_ready  (dsp_snk_ready),
        .dsp_snk_data   (dsp_snk_data),
        .dsp_snk_valid  (dsp_snk_valid),
        .dsp_snk_sop    (dsp_snk_sop),
        .dsp_snk_eop    (dsp_snk_eop),
        .dsp_src_data   (dsp_src_data),
        .dsp_src_valid  (dsp_src_valid),
        .dsp_src_sop    (dsp_src_sop),
        .dsp_src_eop    (dsp_src_eop),
        .dsp_src_ready  (dsp_src_ready),
        .dsp_flush      (dsp_flush),
        .stat_mode      (stat_mode),
        .stat_drain_err (stat_drain_err),
        .stat_byp_pkts  (stat_byp_pkts),
        .stat_dsp_pkts  (stat_dsp_pkts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic [31:0] d, input logic v, input logic s, input logic e);
        snk_data  = d;
        snk_valid = v;
        snk_sop   = s;
        snk_eop   = e;
    endtask

    task automatic drive_dsp(input logic [31:0] d, input logic v, input logic s, input logic e);
        dsp_src_data  = d;
        dsp_src_valid = v;
        dsp_src_sop   = s;
        dsp_src_eop   = e;
    endtask

    initial begin
        int drain_cycles;
        int flushes;

        rst_n          = 1'b0;
        cfg_fir_enable = 1'b0;
        cfg_dft_enable = 1'b0;
        err_clr        = 1'b0;
        src_ready      = 1'b0;
        dsp_snk_ready  = 1'b1;
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        drive_dsp(32'h0, 1'b0, 1'b0, 1'b0);

        // reset state
        #3;
        chk("rst_mode", 32'(stat_mode), 32'd0);
        chk("rst_err", 32'(stat_drain_err), 32'd0);
        chk("rst_flush", 32'(dsp_flush), 32'd0);
        chk("rst_snk_ready", 32'(snk_ready), 32'd0);
        chk("rst_byp_cnt", 32'(stat_byp_pkts), 32'd0);
        chk("rst_dsp_cnt", 32'(stat_dsp_pkts), 32'd0);
        step();
        rst_n     = 1'b1;
        src_ready = 1'b1;
        step();

        // plain bypass: 3 packets of 4 beats
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                drive_in(32'(p * 16 + b), 1'b1, b == 0, b == 3);
                #1;
                chk("byp_data", src_data, 32'(p * 16 + b));
                chk("byp_eop", 32'(src_eop), 32'(b == 3));
                chk("byp_dsp_valid", 32'(dsp_snk_valid), 32'd0);
                step();
            end
        end
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("byp_mode", 32'(stat_mode), 32'd0);
        chk("byp_cnt3", 32'(stat_byp_pkts), STATS ? 32'd3 : 32'd0);

        // enable request mid-packet: switch lands after eop
        drive_in(32'h100, 1'b1, 1'b1, 1'b0);
        step();
        cfg_fir_enable = 1'b1;
        drive_in(32'h101, 1'b1, 1'b0, 1'b0);
        #1;
        chk("sw_b2_mode", 32'(stat_mode), 32'd0);
        step();
        drive_in(32'h102, 1'b1, 1'b0, 1'b0);
        #1;
        chk("sw_b3_mode", 32'(stat_mode), 32'd0);
        chk("sw_b3_data", src_data, 32'h102);
        chk("sw_b3_dsp_valid", 32'(dsp_snk_valid), 32'd0);
        step();
        drive_in(32'h103, 1'b1, 1'b0, 1'b1);
        #1;
        chk("sw_b4_mode", 32'(stat_mode), 32'd0);
        chk("sw_b4_data", src_data, 32'h103);
        step();
        drive_in(32'h200, 1'b1, 1'b1, 1'b0);
        #1;
        chk("sw_dsp_mode", 32'(stat_mode), 32'd1);
        chk("sw_dsp_valid", 32'(dsp_snk_valid), 32'd1);
        chk("sw_dsp_data", dsp_snk_data, 32'h200);
        chk("sw_src_valid", 32'(src_valid), 32'd0);
        chk("sw_snk_ready", 32'(snk_ready), 32'd1);
        step();
        drive_in(32'h201, 1'b1, 1'b0, 1'b1);
        step();
        drive_in(32'h300, 1'b1, 1'b1, 1'b1);
        step();

        // drop enables with 2 packets outstanding
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        cfg_fir_enable = 1'b0;
        step();
        drive_in(32'h400, 1'b1, 1'b1, 1'b0);
        #1;
        chk("dr_mode", 32'(stat_mode), 32'd2);
        chk("dr_snk_ready", 32'(snk_ready), 32'd0);
        chk("dr_dsp_valid", 32'(dsp_snk_valid), 32'd0);
        drive_dsp(32'h55, 1'b1, 1'b1, 1'b1);
        #1;
        chk("dr_src_valid", 32'(src_valid), 32'd1);
        chk("dr_src_data", src_data, 32'h55);
        chk("dr_dsp_ready", 32'(dsp_src_ready), 32'd1);
        step();
        chk("dr_mode_1left", 32'(stat_mode), 32'd2);
        chk("dr_snk_ready_1left", 32'(snk_ready), 32'd0);
        drive_dsp(32'h66, 1'b1, 1'b1, 1'b1);
        step();
        drive_dsp(32'h0, 1'b0, 1'b0, 1'b0);
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("dr_done_mode", 32'(stat_mode), 32'd0);
        chk("dr_done_snk_ready", 32'(snk_ready), 32'd1);
        chk("dr_dsp_cnt2", 32'(stat_dsp_pkts), STATS ? 32'd2 : 32'd0);
        chk("dr_byp_cnt4", 32'(stat_byp_pkts), STATS ? 32'd4 : 32'd0);

        // stuck drain: DSP never returns the eop
        cfg_fir_enable = 1'b1;
        step();
        drive_in(32'h500, 1'b1, 1'b1, 1'b1);
        step();
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        cfg_fir_enable = 1'b0;
        step();
        drain_cycles = 0;
        flushes      = 0;
        for (int i = 0; i < 40; i++) begin
            if (stat_mode != 2'd2)
                break;
            drain_cycles++;
            if (dsp_flush)
                flushes++;
            step();
        end
        chk("to_mode", 32'(stat_mode), 32'd0);
        chk("to_flush_once", 32'(flushes), 32'd1);
        chk("to_drain_cycles", 32'(drain_cycles), 32'd16);
        chk("to_err_set", 32'(stat_drain_err), 32'd1);
        chk("to_flush_low", 32'(dsp_flush), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        chk("to_err_clr", 32'(stat_drain_err), 32'd0);

        // outstanding limit with OUTST_W = 2 and downstream stalled
        src_ready      = 1'b0;
        cfg_dft_enable = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            drive_in(32'(32'h600 + k), 1'b1, 1'b1, 1'b1);
            #1;
            chk("lim_accept", 32'(snk_ready), 32'd1);
            step();
        end
        drive_in(32'h610, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lim_full_ready", 32'(snk_ready), 32'd0);
        chk("lim_full_dsp_valid", 32'(dsp_snk_valid), 32'd0);
        step();
        chk("lim_full_hold", 32'(snk_ready), 32'd0);
        src_ready = 1'b1;
        drive_dsp(32'h77, 1'b1, 1'b1, 1'b1);
        #1;
        chk("lim_out_ready", 32'(dsp_src_ready), 32'd1);
        chk("lim_out_data", src_data, 32'h77);
        step();
        drive_dsp(32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lim_resume_ready", 32'(snk_ready), 32'd1);
        chk("lim_resume_valid", 32'(dsp_snk_valid), 32'd1);
        chk("lim_dsp_cnt3", 32'(stat_dsp_pkts), STATS ? 32'd3 : 32'd0);
        step();
        drive_in(32'h611, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mid_pkt_mode", 32'(stat_mode), 32'd1);

        // reset while mid-packet in DSP
        rst_n = 1'b0;
        #1;
        chk("mrst_mode", 32'(stat_mode), 32'd0);
        chk("mrst_err", 32'(stat_drain_err), 32'd0);
        chk("mrst_flush", 32'(dsp_flush), 32'd0);
        chk("mrst_byp_cnt", 32'(stat_byp_pkts), 32'd0);
        chk("mrst_dsp_cnt", 32'(stat_dsp_pkts), 32'd0);
        cfg_dft_enable = 1'b0;
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        drive_in(32'h700, 1'b1, 1'b1, 1'b0);
        #1;
        chk("post_b0_data", src_data, 32'h700);
        chk("post_b0_dsp_valid", 32'(dsp_snk_valid), 32'd0);
        chk("post_b0_ready", 32'(snk_ready), 32'd1);
        step();
        drive_in(32'h701, 1'b1, 1'b0, 1'b1);
        #1;
        chk("post_b1_data", src_data, 32'h701);
        chk("post_b1_eop", 32'(src_eop), 32'd1);
        step();
        drive_in(32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_mode", 32'(stat_mode), 32'd0);
        chk("post_byp_cnt1", 32'(stat_byp_pkts), STATS ? 32'd1 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
